atm_ctrl_param: RTL and testbench

Parametrised multi-account ATM transaction controller, the successor to the fixed single-table atm block. It holds a provisionable account table of NUM_ACCTS entries, authenticates card/PIN with a per-account retry lockout, and executes balance, deposit, withdraw and transfer operations. Every operation has a fixed latency and returns a one-cycle done pulse with an error code. It sits between the front-panel/keypad sequencer and the host provisioning interface.

---
 rtl/atm_ctrl_param.sv | 278 +++++++++++++++++++++++++++
 tb/tb_atm_ctrl_param.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/atm_ctrl_param.sv
// Multi-account ATM controller: provisionable account table, PIN login with lockout, and
// balance/deposit/withdraw/transfer ops. Define DAILY_LIMIT_EN for the per-session outgoing cap.

module atm_acct_match #(
    parameter int ACCT_W = 12
) (
    input  logic              valid,
    input  logic [ACCT_W-1:0] card,
    input  logic [ACCT_W-1:0] login_card,
    input  logic [ACCT_W-1:0] dest_card,
    output logic              login_hit,
    output logic              dest_hit
);
    assign login_hit = valid && (card == login_card);
    assign dest_hit  = valid && (card == dest_card);
endmodule

module atm_ctrl_param #(
    parameter int NUM_ACCTS   = 4,
    parameter int ACCT_W      = 12,
    parameter int PIN_W       = 8,
    parameter int BAL_W       = 16,
    parameter int AMT_W       = 10,
    parameter int MAX_TRIES   = 3,
    parameter int DAILY_LIMIT = 1000,
    parameter int IDX_W       = (NUM_ACCTS > 1) ? $clog2(NUM_ACCTS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 prov_we,
    input  logic [IDX_W-1:0]     prov_idx,
    input  logic [ACCT_W-1:0]    prov_card,
    input  logic [PIN_W-1:0]     prov_pin,
    input  logic [BAL_W-1:0]     prov_bal,
    input  logic                 card_valid,
    input  logic [ACCT_W-1:0]    card_number,
    input  logic [PIN_W-1:0]     pin_number,
    input  logic                 op_valid,
    input  logic [1:0]           transaction_option,
    input  logic [AMT_W-1:0]     dollars,
    input  logic [ACCT_W-1:0]    wired_account,
    input  logic                 logout,
    output logic                 busy,
    output logic                 authed,
    output logic                 done,
    output logic                 error,
    output logic [2:0]           err_code,
    output logic [BAL_W-1:0]     balance,
    output logic [NUM_ACCTS-1:0] locked
);
    localparam int TRY_W = $clog2(MAX_TRIES + 1);

    localparam logic [2:0] ERR_OK       = 3'd0;
    localparam logic [2:0] ERR_NO_CARD  = 3'd1;
    localparam logic [2:0] ERR_LOCKED   = 3'd2;
    localparam logic [2:0] ERR_BAD_PIN  = 3'd3;
    localparam logic [2:0] ERR_OVERFLOW = 3'd4;
    localparam logic [2:0] ERR_INSUFF   = 3'd5;
    localparam logic [2:0] ERR_BAD_DEST = 3'd6;
    localparam logic [2:0] ERR_LIMIT    = 3'd7;

    localparam logic [1:0] OP_BAL = 2'b00;
    localparam logic [1:0] OP_DEP = 2'b01;
    localparam logic [1:0] OP_WDR = 2'b10;
    localparam logic [1:0] OP_XFR = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_SESSION, S_EXEC} state_t;

    typedef struct packed {
        logic              valid;
        logic [ACCT_W-1:0] card;
        logic [PIN_W-1:0]  pin;
        logic [BAL_W-1:0]  bal;
    } acct_t;

    typedef struct packed {
        logic [1:0]        op;
        logic [AMT_W-1:0]  dollars;
        logic [ACCT_W-1:0] dest;
    } op_req_t;

    state_t            state;
    acct_t             tbl   [NUM_ACCTS];
    logic [TRY_W-1:0]  tries [NUM_ACCTS];
    logic [ACCT_W-1:0] lat_card;
    logic [PIN_W-1:0]  lat_pin;
    op_req_t           req;
    logic [IDX_W-1:0]  sess_idx;

    logic [NUM_ACCTS-1:0] login_hit, dest_hit;
    logic                 login_found, dest_found, login_ok;
    logic [IDX_W-1:0]     login_idx, dest_idx;
    logic [TRY_W:0]       tries_inc;

    logic [BAL_W-1:0] src_bal, dst_bal, amt;
    logic [BAL_W:0]   src_sum, dst_sum;
    logic [2:0]       x_err;
    logic [BAL_W-1:0] x_src_bal, x_dst_bal;
    logic             x_dst_wr;
    logic             lim_over;

    for (genvar g = 0; g < NUM_ACCTS; g++) begin : g_acct
        atm_acct_match #(.ACCT_W(ACCT_W)) u_match (
            .valid      (tbl[g].valid),
            .card       (tbl[g].card),
            .login_card (lat_card),
            .dest_card  (req.dest),
            .login_hit  (login_hit[g]),
            .dest_hit   (dest_hit[g])
        );
    end

    // Scan downward so the lowest matching index is the one left standing.
    always_comb begin
        login_found = 1'b0;
        login_idx   = '0;
        dest_found  = 1'b0;
        dest_idx    = '0;
        for (int i = NUM_ACCTS - 1; i >= 0; i--) begin
            if (login_hit[i]) begin
                login_found = 1'b1;
                login_idx   = IDX_W'(i);
            end
            if (dest_hit[i]) begin
                dest_found = 1'b1;
                dest_idx   = IDX_W'(i);
            end
        end
    end

    assign login_ok  = login_found && !locked[login_idx] && (tbl[login_idx].pin == lat_pin);
    assign tries_inc = {1'b0, tries[login_idx]} + 1'b1;

    assign src_bal = tbl[sess_idx].bal;
    assign dst_bal = tbl[dest_idx].bal;
    assign amt     = BAL_W'(req.dollars);
    assign src_sum = {1'b0, src_bal} + {1'b0, amt};
    assign dst_sum = {1'b0, dst_bal} + {1'b0, amt};

    // Transaction result; any error leaves both balances as they were.
    always_comb begin
        x_err     = ERR_OK;
        x_src_bal = src_bal;
        x_dst_bal = dst_bal;
        x_dst_wr  = 1'b0;
        if (req.dollars != '0) begin
            case (req.op)
                OP_DEP: begin
                    if (src_sum[BAL_W]) x_err = ERR_OVERFLOW;
                    else                x_src_bal = src_sum[BAL_W-1:0];
                end
                OP_WDR: begin
                    if (lim_over)           x_err = ERR_LIMIT;
                    else if (amt > src_bal) x_err = ERR_INSUFF;
                    else                    x_src_bal = src_bal - amt;
                end
                OP_XFR: begin
                    if (!dest_found || dest_idx == sess_idx) x_err = ERR_BAD_DEST;
                    else if (lim_over)                       x_err = ERR_LIMIT;
                    else if (amt > src_bal)                  x_err = ERR_INSUFF;
                    else if (dst_sum[BAL_W])                 x_err = ERR_OVERFLOW;
                    else begin
                        x_src_bal = src_bal - amt;
                        x_dst_bal = dst_sum[BAL_W-1:0];
                        x_dst_wr  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef DAILY_LIMIT_EN
    logic [31:0] out_total;

    assign lim_over = (out_total + 32'(req.dollars)) > 32'(DAILY_LIMIT);

    always_ff @(posedge clk) begin
        if (reset)
            out_total <= '0;
        else if (state == S_LOOKUP && login_ok)
            out_total <= '0;
        else if (state == S_EXEC && x_err == ERR_OK && (req.op == OP_WDR || req.op == OP_XFR))
            out_total <= out_total + 32'(req.dollars);
    end
`else
    assign lim_over = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            authed   <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            err_code <= ERR_OK;
            balance  <= '0;
            locked   <= '0;
            lat_card <= '0;
            lat_pin  <= '0;
            req      <= '0;
            sess_idx <= '0;
            for (int i = 0; i < NUM_ACCTS; i++) begin
                tbl[i]   <= '0;
                tries[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (prov_we && int'(prov_idx) < NUM_ACCTS) begin
                        tbl[prov_idx]    <= '{valid: 1'b1, card: prov_card, pin: prov_pin, bal: prov_bal};
                        tries[prov_idx]  <= '0;
                        locked[prov_idx] <= 1'b0;
                    end
                    if (card_valid) begin
                        lat_card <= card_number;
                        lat_pin  <= pin_number;
                        busy     <= 1'b1;
                        state    <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    if (login_ok) begin
                        tries[login_idx] <= '0;
                        sess_idx         <= login_idx;
                        authed           <= 1'b1;
                        balance          <= tbl[login_idx].bal;
                        error            <= 1'b0;
                        err_code         <= ERR_OK;
                        state            <= S_SESSION;
                    end else begin
                        error <= 1'b1;
                        state <= S_IDLE;
                        if (!login_found)
                            err_code <= ERR_NO_CARD;
                        else if (locked[login_idx])
                            err_code <= ERR_LOCKED;
                        else begin
                            err_code         <= ERR_BAD_PIN;
                            tries[login_idx] <= tries_inc[TRY_W-1:0];
                            if (tries_inc >= (TRY_W+1)'(MAX_TRIES))
                                locked[login_idx] <= 1'b1;
                        end
                    end
                end
                S_SESSION: begin
                    if (logout) begin
                        authed   <= 1'b0;
                        balance  <= '0;
                        error    <= 1'b0;
                        err_code <= ERR_OK;
                        state    <= S_IDLE;
                    end else if (op_valid) begin
                        req   <= '{op: transaction_option, dollars: dollars, dest: wired_account};
                        busy  <= 1'b1;
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    busy               <= 1'b0;
                    done               <= 1'b1;
                    err_code           <= x_err;
                    error              <= (x_err != ERR_OK);
                    balance            <= x_src_bal;
                    tbl[sess_idx].bal  <= x_src_bal;
                    if (x_dst_wr)
                        tbl[dest_idx].bal <= x_dst_bal;
                    state              <= S_SESSION;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_atm_ctrl_param.sv
// Bench for atm_ctrl_param: directed test-plan steps then random ops, checked against
// an account-level reference model.
module tb_atm_ctrl_param;
    localparam int NUM_ACCTS   = 4;
    localparam int ACCT_W      = 12;
    localparam int PIN_W       = 8;
    localparam int BAL_W       = 16;
    localparam int AMT_W       = 10;
    localparam int MAX_TRIES   = 3;
    localparam int DAILY_LIMIT = 1000;
    localparam int IDX_W       = 2;
    localparam int BAL_MAX     = (1 << BAL_W) - 1;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 prov_we = 1'b0;
    logic [IDX_W-1:0]     prov_idx = '0;
    logic [ACCT_W-1:0]    prov_card = '0;
    logic [PIN_W-1:0]     prov_pin = '0;
    logic [BAL_W-1:0]     prov_bal = '0;
    logic                 card_valid = 1'b0;
    logic [ACCT_W-1:0]    card_number = '0;
    logic [PIN_W-1:0]     pin_number = '0;
    logic                 op_valid = 1'b0;
    logic [1:0]           transaction_option = '0;
    logic [AMT_W-1:0]     dollars = '0;
    logic [ACCT_W-1:0]    wired_account = '0;
    logic                 logout = 1'b0;
    logic                 busy, authed, done, error;
    logic [2:0]           err_code;
    logic [BAL_W-1:0]     balance;
    logic [NUM_ACCTS-1:0] locked;

    atm_ctrl_param #(
        .NUM_ACCTS(NUM_ACCTS), .ACCT_W(ACCT_W), .PIN_W(PIN_W), .BAL_W(BAL_W), .AMT_W(AMT_W),
        .MAX_TRIES(MAX_TRIES), .DAILY_LIMIT(DAILY_LIMIT), .IDX_W(IDX_W)
    ) dut (
        .clk(clk), .reset(reset), .prov_we(prov_we), .prov_idx(prov_idx), .prov_card(prov_card),
        .prov_pin(prov_pin), .prov_bal(prov_bal), .card_valid(card_valid), .card_number(card_number),
        .pin_number(pin_number), .op_valid(op_valid), .transaction_option(transaction_option),
        .dollars(dollars), .wired_account(wired_account), .logout(logout), .busy(busy),
        .authed(authed), .done(done), .error(error), .err_code(err_code), .balance(balance),
        .locked(locked)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: accounts as plain integers, session as a few flags.
    bit m_valid [NUM_ACCTS];
    int m_card  [NUM_ACCTS];
    int m_pin   [NUM_ACCTS];
    int m_bal   [NUM_ACCTS];
    int m_tries [NUM_ACCTS];
    bit m_lock  [NUM_ACCTS];
    bit m_authed;
    int m_sidx;
    int m_balout;
    int m_err;
    int m_total;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [31:0] m_lockvec();
        logic [31:0] v = '0;
        for (int i = 0; i < NUM_ACCTS; i++) v[i] = m_lock[i];
        return v;
    endfunction

    function automatic bit m_limit(input int a);
`ifdef DAILY_LIMIT_EN
        return (m_total + a) > DAILY_LIMIT;
`else
        return (a < 0);
`endif
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NUM_ACCTS; i++) begin
            m_valid[i] = 0; m_card[i] = 0; m_pin[i] = 0; m_bal[i] = 0; m_tries[i] = 0; m_lock[i] = 0;
        end
        m_authed = 0; m_sidx = 0; m_balout = 0; m_err = 0; m_total = 0;
    endtask

    task automatic check_state(input string tag);
        check({tag, ".authed"},  32'(authed),   32'(m_authed));
        check({tag, ".balance"}, 32'(balance),  m_balout);
        check({tag, ".error"},   32'(error),    32'(m_err != 0));
        check({tag, ".err"},     32'(err_code), m_err);
        check({tag, ".locked"},  32'(locked),   m_lockvec());
    endtask

    // Strobe was driven at the current negedge; expect busy, then done two edges later.
    task automatic finish_req(input string tag);
        tick();
        card_valid = 1'b0;
        op_valid   = 1'b0;
        check({tag, ".busy1"}, 32'(busy), 32'd1);
        check({tag, ".done_early"}, 32'(done), 32'd0);
        tick();
        check({tag, ".done"}, 32'(done), 32'd1);
        check({tag, ".busy0"}, 32'(busy), 32'd0);
        check_state(tag);
        tick();
        check({tag, ".done_pulse"}, 32'(done), 32'd0);
    endtask

    task automatic provision(input int idx, input int card, input int pin, input int bal);
        prov_we = 1'b1; prov_idx = IDX_W'(idx); prov_card = ACCT_W'(card);
        prov_pin = PIN_W'(pin); prov_bal = BAL_W'(bal);
        tick();
        prov_we = 1'b0;
        if (!m_authed) begin
            m_valid[idx] = 1; m_card[idx] = card; m_pin[idx] = pin; m_bal[idx] = bal;
            m_tries[idx] = 0; m_lock[idx] = 0;
        end
    endtask

    task automatic login(input string tag, input int card, input int pin);
        int f = -1;
        for (int i = 0; i < NUM_ACCTS; i++)
            if (f < 0 && m_valid[i] && m_card[i] == card) f = i;
        if (f < 0) m_err = 1;
        else if (m_lock[f]) m_err = 2;
        else if (m_pin[f] != pin) begin
            m_err = 3;
            m_tries[f]++;
            if (m_tries[f] >= MAX_TRIES) m_lock[f] = 1;
        end else begin
            m_err = 0; m_tries[f] = 0; m_authed = 1; m_sidx = f; m_balout = m_bal[f]; m_total = 0;
        end
        card_valid = 1'b1; card_number = ACCT_W'(card); pin_number = PIN_W'(pin);
        finish_req(tag);
    endtask

    task automatic do_op(input string tag, input int opc, input int a, input int dest);
        int s = m_sidx;
        int d = -1;
        m_err = 0;
        if (a != 0) begin
            if (opc == 1) begin
                if (m_bal[s] + a > BAL_MAX) m_err = 4;
                else m_bal[s] += a;
            end else if (opc == 2) begin
                if (m_limit(a)) m_err = 7;
                else if (a > m_bal[s]) m_err = 5;
                else begin m_bal[s] -= a; m_total += a; end
            end else if (opc == 3) begin
                for (int i = 0; i < NUM_ACCTS; i++)
                    if (d < 0 && m_valid[i] && m_card[i] == dest) d = i;
                if (d < 0 || d == s) m_err = 6;
                else if (m_limit(a)) m_err = 7;
                else if (a > m_bal[s]) m_err = 5;
                else if (m_bal[d] + a > BAL_MAX) m_err = 4;
                else begin m_bal[s] -= a; m_bal[d] += a; m_total += a; end
            end
        end
        m_balout = m_bal[s];
        op_valid = 1'b1; transaction_option = 2'(opc); dollars = AMT_W'(a);
        wired_account = ACCT_W'(dest);
        finish_req(tag);
    endtask

    task automatic do_logout(input string tag);
        logout = 1'b1;
        tick();
        logout = 1'b0;
        m_authed = 0; m_balout = 0; m_err = 0;
        check({tag, ".done"}, 32'(done), 32'd0);
        check_state(tag);
    endtask

    task automatic quiet(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            check({tag, ".no_done"}, 32'(done), 32'd0);
            check({tag, ".no_busy"}, 32'(busy), 32'd0);
        end
    endtask

    initial begin
        int cards [4] = '{100, 200, 300, 400};
        m_reset();
        tick();
        tick();
        check_state("reset");
        check("reset.done", 32'(done), 32'd0);
        check("reset.busy", 32'(busy), 32'd0);
        reset = 1'b0;

        provision(0, 1873, 'h4F, 50000);
        provision(1, 1988, 'h24, 500);

        // unknown card, and strobes ignored in IDLE
        login("t1", 2133, 'h55);
        check("t1.err_const", 32'(err_code), 32'd1);
        op_valid = 1'b1; logout = 1'b1; tick(); op_valid = 1'b0; logout = 1'b0;
        quiet("idle_ign", 2);

        login("t2", 1873, 'h4F);
        do_op("t2.wdr", 2, 250, 0);
        check("t2.bal_const", 32'(balance), 32'd49750);
        do_op("t4.xfr", 3, 1000, 1988);
        check("t4.bal_const", 32'(balance), 32'd48750);
        do_op("t6.self", 3, 10, 1873);
        do_logout("t4.out");

        login("t4.l1988", 1988, 'h24);
        do_op("t4.bal", 0, 0, 0);
        check("t4.1500", 32'(balance), 32'd1500);
        do_op("t4.bad_dest", 3, 5, 2133);
        do_op("t3.wdr1000", 2, 1000, 0);
        do_op("t3.wdr_insuff", 2, 1000, 0);
        check("t3.err5", 32'(err_code), 32'd5);
        do_op("t3.wdr_all", 2, 500, 0);
        check("t3.zero", 32'(balance), 32'd0);
        do_op("zero.dep", 1, 0, 0);
        do_op("zero.wdr", 2, 0, 0);
        provision(1, 1988, 'h24, 9999);           // ignored outside IDLE
        do_op("prov_ign", 0, 0, 0);
        card_valid = 1'b1; card_number = ACCT_W'(2133); tick(); card_valid = 1'b0;
        quiet("sess_card_ign", 2);
        check("sess_card_ign.authed", 32'(authed), 32'd1);
        do_logout("t3.out");

        for (int k = 0; k < 3; k++) login("t5.badpin", 1988, 'h25);
        check("t5.locked1", 32'(locked[1]), 32'd1);
        login("t5.locked", 1988, 'h24);
        check("t5.err2", 32'(err_code), 32'd2);
        provision(1, 1988, 'h24, 500);
        login("t5.reprov", 1988, 'h24);
        do_op("xfr_insuff_first", 3, 600, 2222);
        do_logout("t5.out");

        provision(2, 2222, 'h11, 65000);
        login("t6.l2222", 2222, 'h11);
        do_op("t6.dep_ovf", 1, 1000, 0);
        check("t6.err4", 32'(err_code), 32'd4);
        do_logout("t6.out");
        login("t6.l1873", 1873, 'h4F);
        do_op("t6.dst_ovf", 3, 1000, 2222);
        logout = 1'b1; op_valid = 1'b1; transaction_option = 2'b10; dollars = AMT_W'(1);
        tick();
        logout = 1'b0; op_valid = 1'b0;
        m_authed = 0; m_balout = 0; m_err = 0;
        check_state("t6.logout_op");
        quiet("t6.logout_op", 3);

`ifdef DAILY_LIMIT_EN
        login("lim.login", 1873, 'h4F);
        do_op("lim.w600", 2, 600, 0);
        do_op("lim.w500", 2, 500, 0);
        check("lim.err7", 32'(err_code), 32'd7);
        do_logout("lim.out");
`endif

        // reset while EXEC is in flight
        login("rst.login", 1873, 'h4F);
        op_valid = 1'b1; transaction_option = 2'b10; dollars = AMT_W'(7);
        tick();
        op_valid = 1'b0;
        check("rst.exec_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_reset();
        check_state("rst");
        check("rst.done", 32'(done), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        login("rst.table_clear", 1873, 'h4F);

        // random phase
        for (int i = 0; i < NUM_ACCTS; i++)
            provision(i, cards[i], $urandom_range(0, 255),
                      (i == 3) ? $urandom_range(64500, BAL_MAX) : $urandom_range(0, 3000));
        for (int it = 0; it < 80; it++) begin
            if (!m_authed) begin
                int idx = $urandom_range(0, NUM_ACCTS - 1);
                int r = $urandom_range(0, 9);
                if (m_lock[idx] && r < 5)
                    provision(idx, cards[idx], $urandom_range(0, 255), $urandom_range(0, 3000));
                else if (r == 9)
                    login("rnd.nocard", 999, 0);
                else
                    login("rnd.login", cards[idx], (r < 3) ? (m_pin[idx] ^ 1) : m_pin[idx]);
            end else begin
                int r = $urandom_range(0, 11);
                if (r == 0)
                    do_logout("rnd.logout");
                else
                    do_op("rnd.op", $urandom_range(0, 3), $urandom_range(1, 1023),
                          (r == 1) ? 999 : cards[$urandom_range(0, NUM_ACCTS - 1)]);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
